// File: rtl/lc3_mem_sequencer_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | lc3_mem_pkg : shared types, opcodes and helpers for the LC3 mem stage |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b11,
    IND   = 2'b10,
    READ  = 2'b00,
    WRITE = 2'b01
  } mem_state_t;

  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_STI = 4'b1011;

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
  endfunction

  function automatic logic is_indirect(input logic [3:0] op);
    return (op == OP_LDI) || (op == OP_STI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lc3_mem_sequencer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | lc3_mem_sequencer_if : sequencer <-> MemAccess control/data bus       |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
interface lc3_mem_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [1:0]        mem_state;
  logic              M_control;
  logic [ADDR_W-1:0] M_addr;
  logic [DATA_W-1:0] M_Data;
  logic [DATA_W-1:0] DMem_dout;

  modport master (
    output mem_state,
    output M_control,
    output M_addr,
    output M_Data,
    input  DMem_dout
  );

  modport slave (
    input  mem_state,
    input  M_control,
    input  M_addr,
    input  M_Data,
    output DMem_dout
  );
endinterface
`default_nettype wire

// File: rtl/lc3_mem_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | lc3_mem_sequencer : steps LD/LDR/LDI/ST/STR/STI through memory phases |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module lc3_mem_sequencer
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  wire logic              clock,
  input  wire logic              reset,
  input  wire logic              instr_valid,
  input  wire logic [3:0]        opcode,
  input  wire logic [ADDR_W-1:0] ea,
  input  wire logic [DATA_W-1:0] store_data,
  lc3_mem_sequencer_if.master    bus,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_W-1:0]      load_value,
  output logic                   protocol_err
);

  mem_state_t        state;
  logic              load_op;
  logic              ctrl;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;

  assign bus.mem_state = state;
  assign bus.M_control = ctrl;
  assign bus.M_addr    = addr;
  assign bus.M_Data    = wdata;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      load_op      <= 1'b0;
      ctrl         <= 1'b0;
      addr         <= '0;
      wdata        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      load_value   <= '0;
      protocol_err <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && instr_valid) begin
        protocol_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (instr_valid && (is_load(opcode) || is_store(opcode))) begin
            addr    <= ea;
            load_op <= is_load(opcode);
            busy    <= 1'b1;
            if (is_store(opcode)) begin
              wdata <= store_data;
            end
            if (is_indirect(opcode)) begin
              state <= IND;
            end else if (is_load(opcode)) begin
              state <= READ;
            end else begin
              state <= WRITE;
            end
          end
        end

        // Pointer fetched this cycle becomes the address of the second access.
        IND: begin
          addr  <= bus.DMem_dout;
          ctrl  <= 1'b1;
          state <= load_op ? READ : WRITE;
        end

        READ: begin
          load_value <= bus.DMem_dout;
          ctrl       <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b1;
          state      <= IDLE;
        end

        WRITE: begin
          ctrl  <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end

        default: begin
          ctrl  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lc3_mem_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_lc3_mem_sequencer : directed + random bench with transaction model |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_lc3_mem_sequencer;
  import lc3_mem_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          instr_valid = 1'b0;
  logic [3:0]    opcode = 4'h0;
  logic [AW-1:0] ea = '0;
  logic [DW-1:0] store_data = '0;
  logic          busy;
  logic          done;
  logic [DW-1:0] load_value;
  logic          protocol_err;

  lc3_mem_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  lc3_mem_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock        (clock),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .opcode       (opcode),
    .ea           (ea),
    .store_data   (store_data),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .load_value   (load_value),
    .protocol_err (protocol_err)
  );

  always #5 clock = ~clock;

  // Data memory seen by the DUT, and the model's own copy of it.
  logic [DW-1:0] mem     [0:65535];
  logic [DW-1:0] ref_mem [0:65535];

  assign bus.DMem_dout = mem[bus.M_addr];

  always @(posedge clock) begin
    if (reset && bus.mem_state == 2'b01) mem[bus.M_addr] <= bus.M_Data;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Architectural state the model expects on the outputs.
  logic [AW-1:0] exp_maddr = '0;
  logic [DW-1:0] exp_mdata = '0;
  logic [DW-1:0] exp_lv    = '0;
  logic          exp_perr  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [1:0] ms, input logic mc,
                               input logic bsy, input logic dn);
    check({tag, ".mem_state"},    32'(bus.mem_state), 32'(ms));
    check({tag, ".M_control"},    32'(bus.M_control), 32'(mc));
    check({tag, ".M_addr"},       32'(bus.M_addr),    32'(exp_maddr));
    check({tag, ".M_Data"},       32'(bus.M_Data),    32'(exp_mdata));
    check({tag, ".busy"},         32'(busy),          32'(bsy));
    check({tag, ".done"},         32'(done),          32'(dn));
    check({tag, ".load_value"},   32'(load_value),    32'(exp_lv));
    check({tag, ".protocol_err"}, 32'(protocol_err),  32'(exp_perr));
  endtask

  task automatic present(input logic [3:0] op, input logic [AW-1:0] a, input logic [DW-1:0] sd);
    opcode      = op;
    ea          = a;
    store_data  = sd;
    instr_valid = 1'b1;
    @(posedge clock);
    #1 instr_valid = 1'b0;
  endtask

  // Starts and ends on a falling edge; the final cycle checked is the done cycle,
  // so consecutive calls present the next op in that cycle with no idle gap.
  task automatic run_op(input logic [3:0] op, input logic [AW-1:0] a,
                        input logic [DW-1:0] sd, input bit inject);
    logic          ld;
    logic          st;
    logic          ind;
    logic [AW-1:0] ptr;
    logic          mc;
    ld  = (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
    st  = (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
    ind = (op == OP_LDI) || (op == OP_STI);
    present(op, a, sd);
    if (!(ld || st)) begin
      @(negedge clock);
      check_outputs("nop", 2'b11, 1'b0, 1'b0, 1'b0);
      return;
    end
    exp_maddr = a;
    if (st) exp_mdata = sd;
    ptr = a;
    mc  = 1'b0;
    if (ind) begin
      ptr = ref_mem[a];
      @(negedge clock);
      check_outputs("ind", 2'b10, 1'b0, 1'b1, 1'b0);
      if (inject) begin
        exp_perr = 1'b1;
        present(OP_LD, AW'($urandom), DW'($urandom));
      end
      exp_maddr = ptr;
      mc = 1'b1;
    end
    @(negedge clock);
    check_outputs(ld ? "read" : "write", ld ? 2'b00 : 2'b01, mc, 1'b1, 1'b0);
    if (ld) exp_lv = ref_mem[ptr];
    else    ref_mem[ptr] = sd;
    @(negedge clock);
    check_outputs("done", 2'b11, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [3:0] ops [6];
    logic [3:0] op;
    logic [DW-1:0] v;
    ops[0] = OP_LD; ops[1] = OP_LDR; ops[2] = OP_LDI;
    ops[3] = OP_ST; ops[4] = OP_STR; ops[5] = OP_STI;

    for (int i = 0; i < 65536; i++) begin
      v = DW'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[16'h3010] = 16'hBEEF; ref_mem[16'h3010] = 16'hBEEF;
    mem[16'h3000] = 16'h4000; ref_mem[16'h3000] = 16'h4000;
    mem[16'h4000] = 16'h1234; ref_mem[16'h4000] = 16'h1234;
    mem[16'h3002] = 16'h5000; ref_mem[16'h3002] = 16'h5000;

    repeat (3) @(negedge clock);
    check_outputs("reset", 2'b11, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clock);

    run_op(OP_LD,  16'h3010, 16'h0000, 1'b0);
    check("ld_value", 32'(load_value), 32'h0000BEEF);
    @(negedge clock);
    run_op(OP_LDI, 16'h3000, 16'h0000, 1'b0);
    check("ldi_value", 32'(load_value), 32'h00001234);
    @(negedge clock);
    run_op(OP_STI, 16'h3002, 16'hA5A5, 1'b0);
    run_op(OP_LD,  16'h5000, 16'h0000, 1'b0);
    check("sti_readback", 32'(load_value), 32'h0000A5A5);
    @(negedge clock);

    // Back-to-back LDR then STR, second presented in the done cycle.
    run_op(OP_LDR, 16'h3010, 16'h0000, 1'b0);
    run_op(OP_STR, 16'h3123, 16'h5A5A, 1'b0);
    run_op(OP_LDR, 16'h3123, 16'h0000, 1'b0);
    @(negedge clock);

    // Instruction arriving while busy is dropped and flags an error.
    run_op(OP_LDI, 16'h3000, 16'h0000, 1'b1);
    check("perr_ldi_value", 32'(load_value), 32'h00001234);
    repeat (2) @(negedge clock);
    check_outputs("perr_idle", 2'b11, 1'b0, 1'b0, 1'b0);

    // Reset during IND of an LDI.
    present(OP_LDI, 16'h3000, 16'h0000);
    @(negedge clock);
    reset = 1'b0;
    #1;
    exp_maddr = '0; exp_mdata = '0; exp_lv = '0; exp_perr = 1'b0;
    check_outputs("mid_reset", 2'b11, 1'b0, 1'b0, 1'b0);
    repeat (2) begin
      @(negedge clock);
      check_outputs("reset_hold", 2'b11, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b1;
    @(negedge clock);
    check_outputs("after_release", 2'b11, 1'b0, 1'b0, 1'b0);
    run_op(OP_LD, 16'h3010, 16'h0000, 1'b0);

    // Non-memory opcode is a no-op.
    run_op(4'b0001, 16'h1111, 16'h2222, 1'b0);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) op = 4'($urandom);
      else                            op = ops[$urandom_range(0, 5)];
      run_op(op, AW'($urandom), DW'($urandom), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) @(negedge clock);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/lc3_mem_sequencer.md
# lc3_mem_sequencer

Memory-stage sequencer for the LC3 pipeline, sitting directly upstream of the MemAccess stage. It drives MemAccess's control and operand inputs (mem_state, M_control, M_addr, M_Data) and observes DMem_dout. On accepting a decoded load or store it steps through the required memory phases, including the pointer-fetch phase of LDI and STI. It also provides a busy/stall signal to fetch/decode, a done pulse, and the latched load result.

## Interface
- ADDR_W, 16, address width of M_addr.
- DATA_W, 16, width of M_Data, DMem_dout and load_value.
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- instr_valid  input  1  one-cycle pulse: a decoded instruction is presented to the memory stage.
- opcode  input  4  IR[15:12] of the presented instruction.
- ea  input  ADDR_W  effective address computed by Execute.
- store_data  input  DATA_W  source register value for stores.
- DMem_dout  input  DATA_W  data-memory read data; combinational from the current M_addr.
- mem_state  output  2  memory phase: 2'b00 read, 2'b01 write, 2'b10 indirect pointer read, 2'b11 idle.
- M_control  output  1  1 on the second access of LDI/STI (address is the fetched pointer).
- M_addr  output  ADDR_W  memory address for the current phase.
- M_Data  output  DATA_W  write data, latched at accept.
- busy  output  1  high whenever the FSM is not in IDLE; upstream stalls on it.
- done  output  1  one-cycle pulse in the cycle after the final access.
- load_value  output  DATA_W  DMem_dout captured at the end of the READ phase.
- protocol_err  output  1  sticky; set when instr_valid arrives while busy.

## Operation
- States:
  - IDLE (mem_state 11)
  - IND (10)
  - READ (00)
  - WRITE (01)
- All outputs are registered.
- Reset value of every output is 0, except mem_state, which resets to 2'b11.
- Accepted opcodes:
  - Loads: LD 0010, LDR 0110, LDI 1010.
  - Stores: ST 0011, STR 0111, STI 1011.
- Other opcodes with instr_valid: no state change, no done pulse, no error.
- Accept happens in IDLE with instr_valid and a memory opcode:
  - latch M_addr←ea;
  - latch M_Data←store_data on stores only; M_Data holds its previous value otherwise.
- Next state after accept:
  - IND for LDI/STI;
  - READ for LD/LDR;
  - WRITE for ST/STR.
- IND, one cycle: at its end, M_addr←DMem_dout and M_control←1. Next state is READ for LDI, WRITE for STI.
- READ, one cycle: at its end, load_value←DMem_dout. Return to IDLE and assert done.
- WRITE, one cycle: return to IDLE and assert done.
- On every return to IDLE, M_control clears to 0.
- M_addr holds its last value while in IDLE.
- instr_valid while busy: ignored, and protocol_err is set. It clears only on reset.
- Accept is legal in the same cycle that done is high, because that cycle is IDLE.

## Timing
- Accept edge = E0.
- Direct ops: access phase occupies cycle E0→E1; done is high in E1→E2. Total latency: 2 edges from accept to done.
- Indirect ops: IND occupies E0→E1, the second access E1→E2, done E2→E3. Total latency: 3 edges.
- busy is high exactly during the access phases.
- Back-to-back throughput: one direct op per 2 cycles.
- Reset mid-operation: immediate return to IDLE.
  - All outputs take their reset values asynchronously.
  - A pending done is dropped and an in-flight write is abandoned.
  - load_value is not updated.

## Structure
- A shared package lc3_mem_pkg holds:
  - the mem_state_t enum (IDLE=2'b11, IND=2'b10, READ=2'b00, WRITE=2'b01);
  - opcode localparams OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI;
  - helper functions is_load, is_store, is_indirect.
- The FSM state register is typed mem_state_t, and mem_state is driven directly from it.
- No sub-module: a single FSM module.

## Test plan
- Reset, then LD with ea=16'h3010 and DMem[3010]=16'hBEEF.
  - Cycle after accept: mem_state=00, M_addr=3010.
  - Next cycle: done=1, load_value=BEEF.
- LDI with ea=16'h3000, DMem[3000]=16'h4000, DMem[4000]=16'h1234.
  - Phases IND(M_addr 3000) → READ(M_addr 4000, M_control=1).
  - done 3 edges after accept, load_value=1234.
- STI with ea=16'h3002, DMem[3002]=16'h5000, store_data=16'hA5A5.
  - IND → WRITE with M_addr=5000, M_Data=A5A5, M_control=1.
  - Then IDLE with M_control=0.
- STR accepted in the done cycle of a preceding LDR: no idle gap, and both complete correctly.
- Second instr_valid (LD) while busy with LDI: it is ignored, protocol_err=1 and stays set, and the LDI result is unaffected.
- reset low during the IND phase of LDI: outputs take their reset values (mem_state=11, M_control=0, M_addr=0, M_Data=0, busy=0, done=0, load_value=0, protocol_err=0), no done appears, and the next LD after release completes normally.
